// File: rtl/fetch_sequencer.sv
// Fetch controller: registers instr into ir, resolves branches/halt from ir and steers the PC via PCSrc/immediate.
// Fetch-to-ir 1 edge, taken branch costs 1 squash bubble; stall holds ir, state and counter, HALT freezes until reset.
module fetch_sequencer (
  input  logic        CLK,
  input  logic        reset,
  input  logic [23:0] instr,
  input  logic        zero,
  input  logic        stall,
  output logic        PCSrc,
  output logic [7:0]  immediate,
  output logic [23:0] ir,
  output logic        ir_valid,
  output logic        halted,
  output logic [7:0]  taken_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] ir_nxt;
  logic        ir_valid_nxt;
  logic [7:0]  taken_cnt_nxt;
  logic [3:0]  opcode;
  logic        br_taken;
  logic        is_halt;

  assign opcode  = ir[23:20];
  assign is_halt = (opcode == 4'hF);
  assign halted  = (state == S_HALT);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      4'hC:    br_taken = zero;
      4'hD:    br_taken = ~zero;
      4'hE:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    taken_cnt_nxt = taken_cnt;
    PCSrc         = 1'b0;
    immediate     = 8'h00;
    // Hold is PC + 0; HALT outranks stall so a frozen sequencer never moves.
    if (state == S_HALT || stall) begin
      PCSrc = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (br_taken) begin
            PCSrc         = 1'b1;
            immediate     = ir[7:0];
            ir_nxt        = 24'h0;
            ir_valid_nxt  = 1'b0;
            taken_cnt_nxt = taken_cnt + 8'd1;
            state_nxt     = S_FLUSH;
          end else if (is_halt) begin
            ir_valid_nxt = 1'b0;
            state_nxt    = S_HALT;
          end else begin
            ir_nxt       = instr;
            ir_valid_nxt = 1'b1;
          end
        end
        S_FLUSH: begin
          ir_nxt       = instr;
          ir_valid_nxt = 1'b1;
          state_nxt    = S_RUN;
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      ir        <= 24'h0;
      ir_valid  <= 1'b0;
      taken_cnt <= 8'h00;
    end else begin
      state     <= state_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      taken_cnt <= taken_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: bench-side PC/memory datapath, directed scenarios plus randomized programs vs an address-level model.
module tb_fetch_sequencer;
  logic        CLK;
  logic        reset;
  logic [23:0] instr;
  logic        zero;
  logic        stall;
  logic        PCSrc;
  logic [7:0]  immediate;
  logic [23:0] ir;
  logic        ir_valid;
  logic        halted;
  logic [7:0]  taken_cnt;

  logic [23:0] mem [256];
  logic [7:0]  pc;
  int          n_checks;
  int          n_fail;

  fetch_sequencer dut (
    .CLK(CLK), .reset(reset), .instr(instr), .zero(zero), .stall(stall),
    .PCSrc(PCSrc), .immediate(immediate), .ir(ir), .ir_valid(ir_valid),
    .halted(halted), .taken_cnt(taken_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath fixture: PC register plus instruction memory.
  assign instr = mem[pc];
  always @(posedge CLK or negedge reset) begin
    if (!reset) pc <= 8'h00;
    else        pc <= PCSrc ? pc + immediate : pc + 8'd1;
  end

  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    zero  = 1'b0;
    @(posedge CLK);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[1] = 24'hC00005;
    do_reset();
    nxt();
    nxt();
    stall = 1'b1; zero = 1'b1; #1;
    n_checks++; if ({PCSrc, immediate} !== 9'h100) begin n_fail++; $display("FAIL rst_stall_hold: got %b/%h want 1/00", PCSrc, immediate); end
    nxt();
    n_checks++; if (ir !== 24'hC00005) begin n_fail++; $display("FAIL rst_stall_ir: got %h want C00005", ir); end
    reset = 1'b0; stall = 1'b0; #1;
    n_checks++; if (ir !== 24'h0) begin n_fail++; $display("FAIL rst_ir: got %h want 000000", ir); end
    n_checks++; if ({ir_valid, halted} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got v=%b h=%b want 0 0", ir_valid, halted); end
    n_checks++; if (taken_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_cnt: got %h want 00", taken_cnt); end
    n_checks++; if ({PCSrc, immediate} !== 9'h000) begin n_fail++; $display("FAIL rst_pcsrc: got %b/%h want 0/00", PCSrc, immediate); end
    clear_mem();
    nxt();
    reset = 1'b1; #1;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_v: got %b want 0", ir_valid); end
    nxt();
    n_checks++; if ({ir_valid, PCSrc} !== 2'b10) begin n_fail++; $display("FAIL rst_first_fetch: got v=%b pcsrc=%b want 1 0", ir_valid, PCSrc); end
  endtask

  task automatic test_uncond();
    clear_mem();
    mem[1] = 24'hE00002; mem[2] = 24'h111111; mem[3] = 24'h222222; mem[4] = 24'h333333;
    do_reset();
    nxt();
    n_checks++; if ({ir_valid, ir} !== {1'b1, 24'h000000}) begin n_fail++; $display("FAIL br_c0: got v=%b ir=%h want 1 000000", ir_valid, ir); end
    nxt();
    n_checks++; if ({ir_valid, ir} !== {1'b1, 24'hE00002}) begin n_fail++; $display("FAIL br_c1: got v=%b ir=%h want 1 E00002", ir_valid, ir); end
    n_checks++; if ({PCSrc, immediate} !== 9'h102) begin n_fail++; $display("FAIL br_redirect: got %b/%h want 1/02", PCSrc, immediate); end
    nxt();
    n_checks++; if ({ir_valid, ir} !== {1'b0, 24'h000000}) begin n_fail++; $display("FAIL br_squash: got v=%b ir=%h want 0 000000", ir_valid, ir); end
    n_checks++; if (taken_cnt !== 8'h01) begin n_fail++; $display("FAIL br_cnt: got %h want 01", taken_cnt); end
    nxt();
    n_checks++; if ({ir_valid, ir} !== {1'b1, 24'h333333}) begin n_fail++; $display("FAIL br_target: got v=%b ir=%h want 1 333333", ir_valid, ir); end
  endtask

  task automatic test_cond();
    logic [23:0] opw [3];
    logic        zv  [3];
    logic        tk  [3];
    opw[0] = 24'hC00003; zv[0] = 1'b0; tk[0] = 1'b0;
    opw[1] = 24'hC00003; zv[1] = 1'b1; tk[1] = 1'b1;
    opw[2] = 24'hD00003; zv[2] = 1'b1; tk[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      mem[1] = opw[k]; mem[2] = 24'h111111; mem[5] = 24'h555555;
      do_reset();
      nxt();
      nxt();
      zero = zv[k]; #1;
      n_checks++; if ({PCSrc, immediate} !== (tk[k] ? 9'h103 : 9'h000)) begin n_fail++; $display("FAIL cond%0d_pcsrc: got %b/%h want taken=%b", k, PCSrc, immediate, tk[k]); end
      nxt();
      if (tk[k]) begin
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL cond%0d_bubble: got v=%b want 0", k, ir_valid); end
        nxt();
        n_checks++; if ({ir_valid, ir} !== {1'b1, 24'h555555}) begin n_fail++; $display("FAIL cond%0d_target: got v=%b ir=%h want 1 555555", k, ir_valid, ir); end
      end else begin
        n_checks++; if ({ir_valid, ir} !== {1'b1, 24'h111111}) begin n_fail++; $display("FAIL cond%0d_fall: got v=%b ir=%h want 1 111111", k, ir_valid, ir); end
      end
    end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[1] = 24'hE00002; mem[4] = 24'h333333;
    do_reset();
    nxt();
    nxt();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; #1;
      n_checks++; if ({PCSrc, immediate, ir} !== {1'b1, 8'h00, 24'hE00002}) begin n_fail++; $display("FAIL stall%0d: got %b/%h ir=%h want 1/00 E00002", i, PCSrc, immediate, ir); end
      nxt();
    end
    stall = 1'b0; #1;
    n_checks++; if ({PCSrc, immediate, taken_cnt} !== {1'b1, 8'h02, 8'h00}) begin n_fail++; $display("FAIL stall_release: got %b/%h cnt=%h want 1/02 00", PCSrc, immediate, taken_cnt); end
    nxt();
    n_checks++; if ({ir_valid, taken_cnt} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL stall_resolve: got v=%b cnt=%h want 0 01", ir_valid, taken_cnt); end
    nxt();
    n_checks++; if (ir !== 24'h333333) begin n_fail++; $display("FAIL stall_target: got %h want 333333", ir); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[2] = 24'hF00000; mem[3] = 24'h333333;
    do_reset();
    nxt();
    nxt();
    nxt();
    n_checks++; if ({ir_valid, halted, ir} !== {2'b10, 24'hF00000}) begin n_fail++; $display("FAIL halt_enter: got v=%b h=%b ir=%h want 1 0 F00000", ir_valid, halted, ir); end
    for (int i = 0; i < 8; i++) begin
      nxt();
      stall = 1'($urandom_range(0, 1)); #1;
      n_checks++; if ({halted, ir_valid, PCSrc, immediate, ir} !== {3'b101, 8'h00, 24'hF00000}) begin n_fail++; $display("FAIL halt_frozen%0d: got h=%b v=%b %b/%h ir=%h", i, halted, ir_valid, PCSrc, immediate, ir); end
    end
    do_reset();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_recover: got %b want 0", halted); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 24'hE0FFFF;
    do_reset();
    nxt();
    for (int k = 0; k < 255; k++) begin
      nxt();
      nxt();
    end
    n_checks++; if ({taken_cnt, ir} !== {8'hFF, 24'hE0FFFF}) begin n_fail++; $display("FAIL wrap_ff: got cnt=%h ir=%h want FF E0FFFF", taken_cnt, ir); end
    nxt();
    n_checks++; if (taken_cnt !== 8'h00) begin n_fail++; $display("FAIL wrap_00: got %h want 00", taken_cnt); end
  endtask

  // Address-level model: tracks which memory word should occupy ir, independent of the bench PC.
  task automatic test_random();
    logic [23:0] e_ir;
    logic        e_v, e_h, e_tk, e_ps;
    logic [7:0]  e_cnt, e_imm, next_addr;
    int unsigned r;
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 99);
        if (r < 62)      mem[i] = {4'($urandom_range(0, 11)), 20'($urandom)};
        else if (r < 97) mem[i] = {4'($urandom_range(12, 14)), 12'($urandom), 8'($urandom_range(1, 12))};
        else             mem[i] = {4'hF, 20'($urandom)};
      end
      do_reset();
      e_ir = 24'h0; e_v = 1'b0; e_h = 1'b0; e_cnt = 8'h00; next_addr = 8'h00;
      for (int c = 0; c < 80; c++) begin
        stall = ($urandom_range(0, 4) == 0);
        zero  = 1'($urandom_range(0, 1));
        #1;
        e_tk = !e_h && ((e_ir[23:20] == 4'hE) || (e_ir[23:20] == 4'hC && zero) || (e_ir[23:20] == 4'hD && !zero));
        e_ps = e_h || stall || e_tk;
        e_imm = (!e_h && !stall && e_tk) ? e_ir[7:0] : 8'h00;
        n_checks++; if ({ir_valid, ir} !== {e_v, e_ir}) begin n_fail++; $display("FAIL rnd%0d.%0d_ir: got v=%b ir=%h want v=%b ir=%h", seg, c, ir_valid, ir, e_v, e_ir); end
        n_checks++; if ({halted, taken_cnt} !== {e_h, e_cnt}) begin n_fail++; $display("FAIL rnd%0d.%0d_hc: got h=%b cnt=%h want h=%b cnt=%h", seg, c, halted, taken_cnt, e_h, e_cnt); end
        n_checks++; if ({PCSrc, immediate} !== {e_ps, e_imm}) begin n_fail++; $display("FAIL rnd%0d.%0d_pc: got %b/%h want %b/%h", seg, c, PCSrc, immediate, e_ps, e_imm); end
        if (!e_h && !stall) begin
          if (e_tk) begin
            next_addr = next_addr + e_ir[7:0];
            e_ir = 24'h0; e_v = 1'b0; e_cnt = e_cnt + 8'd1;
          end else if (e_ir[23:20] == 4'hF) begin
            e_h = 1'b1; e_v = 1'b0;
          end else begin
            e_ir = mem[next_addr]; e_v = 1'b1; next_addr = next_addr + 8'd1;
          end
        end
        nxt();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    stall    = 1'b0;
    zero     = 1'b0;
    clear_mem();
    test_reset();
    test_uncond();
    test_cond();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
